// File: rtl/serial_adder_defs.sv
// Shared definitions for the nibble-serial adder: state encoding and nibble width.
package serial_adder_defs;

  localparam int unsigned NIBBLE = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder: the shared datapath reused nibble by nibble.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder streaming 4 bits per cycle through one ripple adder.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import serial_adder_defs::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N = WIDTH / NIBBLE;
  localparam logic [3:0] LAST = 4'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
  end
  if (N > 16) begin : g_bad_count
    $error("nibble_serial_adder: WIDTH exceeds the 4-bit nibble counter range");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [3:0]       cnt_q;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             accept;
  logic             last;
  logic [WIDTH+3:0] res_shift;

  ripple_carry_adder_4bit u_rca (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign accept    = in_valid && in_ready;
  assign last      = (state_q == StRun) && (cnt_q == LAST);
  // New nibble enters at the MSB end; after N shifts nibble 0 sits at the bottom.
  assign res_shift = {nib_sum, res_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (cnt_q == LAST) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> NIBBLE;
      b_q     <= b_q >> NIBBLE;
      res_q   <= res_shift[WIDTH+3:4];
      carry_q <= nib_cout;
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  assign sum  = res_q;
  assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last nibble the low bits of a_q/b_q hold the operand MSBs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= a_q[3] ^ b_q[3] ^ nib_sum[3] ^ nib_cout;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=8 instances).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf, ovf8;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction, called at a negedge with the block idle or about to be.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input int hold, input bit noise, input string tag);
    logic [16:0] exp;
    int          lat;
    int          guard;
    exp      = {1'b0, ta} + {1'b0, tb} + 17'(tc);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = noise;
    if (noise) begin
      a   = ~ta;
      b   = ta ^ 16'h5a5a;
      cin = ~tc;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'd4);
    check({tag, ":sum"}, 64'(sum), 64'(exp[15:0]));
    check({tag, ":cout"}, 64'(cout), 64'(exp[16]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ":ovf"}, 64'(ovf), 64'((ta[15] == tb[15]) && (exp[15] != ta[15])));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_sum"}, 64'({cout, sum}), 64'(exp));
      check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ":idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, ":sum_kept"}, 64'({cout, sum}), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    int          lat8;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    a8         = '0;
    b8         = '0;
    cin8       = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst:in_ready", 64'(in_ready), 64'd0);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:sum", 64'(sum), 64'd0);
    check("rst:cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst:ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel:in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "wrap");
    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, "mix");
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "b2b");
    run_op(16'hA5C3, 16'h1F0E, 1'b1, 5, 1'b1, "bp");
`ifdef SERIAL_ADDER_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "ovf_pos");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ovf_neg");
`endif

    // Abort an operation after two nibbles.
    a        = 16'hFFFF;
    b        = 16'h1111;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst:in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("midrst:in_ready", 64'(in_ready), 64'd1);
    check("midrst:out_valid", 64'(out_valid), 64'd0);
    check("midrst:sum", 64'(sum), 64'd0);
    check("midrst:cout", 64'(cout), 64'd0);
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "after_rst");

    for (int n = 0; n < 16; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), "rand");
    end

    // Narrow instance: two nibbles, so two edges from accept to out_valid.
    a8        = 8'hF0;
    b8        = 8'h10;
    cin8      = 1'b0;
    in_valid8 = 1'b1;
    check("w8:in_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat8      = 0;
    while (!out_valid8 && lat8 < 40) begin
      @(negedge clk);
      lat8++;
    end
    check("w8:latency", 64'(lat8), 64'd2);
    check("w8:sum", 64'(sum8), 64'h00);
    check("w8:cout", 64'(cout8), 64'd1);
    @(negedge clk);
    check("w8:valid_drop", 64'(out_valid8), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder for WIDTH-bit operands. It accepts an operand pair over a valid/ready handshake and streams the operands 4 bits per cycle through one `ripple_carry_adder_4bit`, with the carry registered between nibbles. It presents the full sum and carry-out over a second valid/ready handshake. It sits directly upstream of the 4-bit ripple adder, sequencing its inputs and collecting its outputs, so wide additions reuse the existing 4-bit datapath.

## Interface
- `WIDTH`, 16: operand/sum width. Must be a multiple of 4 and ≥ 4.
- `clk`  input  1  clock. All state updates on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is synchronous and active-low.
- `in_valid`  input  1  operand pair offered.
- `in_ready`  output  1  block can accept an operand pair.
- `a`  input  WIDTH  operand A, unsigned or two's complement.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in to nibble 0.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer takes the result.
- `sum`  output  WIDTH  a + b + cin, mod 2^WIDTH.
- `cout`  output  1  carry out of bit WIDTH-1.
- `ovf`  output  1  signed overflow. Present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- N = WIDTH/4 nibbles. 4-bit counter `cnt`, 0..N-1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `a`, `b` into shift registers and `cin` into the carry register, clear `cnt`, go to RUN.
  - RUN: each cycle the adder sees the low nibbles of the A/B shift registers plus the carry register. At the edge:
    - adder sum nibble shifts into the top of the result register, from MSB toward LSB;
    - A/B shift right by 4;
    - carry register ← adder cout;
    - `cnt`++.
  - RUN exit: when `cnt`==N-1 at the edge, go to DONE.
  - DONE: `out_valid`=1. `sum`/`cout` are stable. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is low in RUN and DONE. `in_valid` is ignored there and nothing is queued.
- `out_valid` drops in the cycle after the handshake. `sum`/`cout`/`ovf` hold the last result until the next accept overwrites the registers.
- Arithmetic is mod 2^WIDTH. No saturation.
- Reset (`rst_n`=0 at an edge) from any state: state → IDLE, `cnt`, shift registers, carry, `sum`, `cout`, `ovf` → 0. In-flight operation is discarded with no output. `in_ready`=0 while `rst_n` is low.

## Timing
- Reset values: `in_ready` 0 during reset and 1 in the first cycle after release; `out_valid` 0, `sum` 0, `cout` 0, `ovf` 0.
- Accept edge at cycle T → `out_valid` high from cycle T+N. The result is registered; no combinational path from inputs to outputs.
- Best-case throughput: one operation per N+2 cycles with `out_ready` held high (accept, N RUN cycles, handshake, IDLE).
- `in_ready` depends only on state and `rst_n`, never combinationally on `in_valid`.
- `out_valid` never depends on `out_ready`.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - adds port `ovf`;
  - `ovf` = (carry into bit WIDTH-1) XOR `cout`, where carry into MSB = a[W-1]^b[W-1]^sum[W-1] computed from registered MSBs;
  - updated with `sum`; reset value 0.
- Not defined: no `ovf` port and no extra registers; all other behaviour is identical.

## Structure
- Shared package/include `serial_adder_defs` holds the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the nibble width constant 4.
- The single sub-module is the existing `ripple_carry_adder_4bit`, instantiated once. Its ports are `a`, `b`, `cin`, `sum`, `cout`. No other sub-modules.
- Static check: WIDTH%4 != 0 is a compile-time error (generate-time `$error`/invalid instance).

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, `out_valid` exactly 4 cycles after the accept edge.
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. Then back-to-back op a=0x8000, b=0x8000 → sum=0x0000, cout=1, accepted on the cycle `in_ready` returns.
- Backpressure:
  - hold `out_ready`=0 for 5 cycles in DONE → `sum`/`cout` stable, `in_ready`=0;
  - pulse `in_valid` with a new pair during RUN/DONE → ignored; the next result reflects only the original pair.
- Reset mid-RUN after 2 nibbles → next cycle all outputs 0, `in_ready`=1. A following op 0x0001+0x0001 gives 0x0002, cout=0.
- With `SERIAL_ADDER_OVF_EN`:
  - 0x7FFF+0x0001 → sum 0x8000, ovf=1, cout=0;
  - 0xFFFF+0x0001 → ovf=0, cout=1.
- WIDTH=8: 0xF0+0x10, cin=0 → sum=0x00, cout=1, latency 2 cycles.
